// File: rtl/uart_pkg.sv
// Shared UART constants and the TX scheduler state encoding.
// The transmitter and receiver use the same baud/frame constants.
package uart_pkg;

  localparam int BAUD_END     = 5208;
  localparam int BIT_END      = 10;
  localparam int FRAME_CYCLES = BAUD_END * BIT_END;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_WAIT  = ST_WAIT
  } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: lowest valid index above i_rr_ptr, else lowest valid index.
// Purely combinational; o_grant is one-hot or zero.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_hi;
  logic [NUM_REQ-1:0] w_sel;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (i > int'(i_rr_ptr));
    end
    w_hi  = i_valid & w_mask;
    // Nothing valid above the pointer means the scan wraps to index 0.
    w_sel = (|w_hi) ? w_hi : i_valid;
    o_any = |i_valid;
    o_grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_sel[i]) o_grant_idx = IDX_W'(i);
    end
    o_grant = o_any ? (NUM_REQ'(1) << o_grant_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-serial UART transmitter among NUM_REQ
// producers. The transmitter has no done output, so the frame is timed here.
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int BAUD_END     = uart_pkg::BAUD_END,
  parameter int BIT_END      = uart_pkg::BIT_END,
  parameter int FRAME_CYCLES = BAUD_END * BIT_END,
  parameter int CNT_W        = $clog2(FRAME_CYCLES),
  parameter int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                   sclk,
  input  logic                   s_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_flag,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_id
);

  import uart_pkg::sched_state_t;
  import uart_pkg::S_IDLE;
  import uart_pkg::S_START;
  import uart_pkg::S_WAIT;

  sched_state_t       r_state;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_any;
  logic               w_take;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_valid     (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_grant_any)
  );

  // Handshake: a byte is taken only in IDLE, and never while reset is held.
  assign w_take    = s_rst_n && (r_state == S_IDLE) && w_grant_any;
  assign req_ready = w_take ? w_grant : '0;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state     <= S_IDLE;
      tx_flag     <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      r_frame_cnt <= '0;
      r_rr_ptr    <= IDX_W'(NUM_REQ - 1);
    end else begin
      tx_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            tx_data  <= req_data[{w_grant_idx, 3'b000} +: 8];
            grant_id <= w_grant_idx;
            r_rr_ptr <= w_grant_idx;
            tx_flag  <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          r_frame_cnt <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          // START is frame cycle 0, so IDLE is re-entered FRAME_CYCLES after tx_flag.
          if (r_frame_cnt == CNT_W'(FRAME_CYCLES - 2)) begin
            r_frame_cnt <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed and random bench for uart_tx_sched with a frame-level reference
// model, a behavioural transmitter/line model and a serial line decoder.
module tb_uart_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int BAUD    = 8;
  localparam int BITS    = 10;
  localparam int FC      = BAUD * BITS;

  logic                 sclk = 1'b0;
  logic                 s_rst_n = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_flag;
  logic [7:0]           tx_data;
  logic                 busy;
  logic [1:0]           grant_id;

  uart_tx_sched #(
    .NUM_REQ  (NUM_REQ),
    .BAUD_END (BAUD),
    .BIT_END  (BITS)
  ) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_flag   (tx_flag),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // ---------------- clock / watchdog ----------------
  always #5 sclk = ~sclk;

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: cycles left until the scheduler is free again.
  int         m_left;
  int         m_ptr;
  logic [7:0] m_data;
  int         m_gid;
  int         hs_w;
  logic       auto_clear = 1'b1;

  logic [7:0] exp_q[$];
  int         got_q[$];
  int         flag_cyc[$];

  // Transmitter and line decoder models.
  logic       work_en;
  int         tx_pos;
  logic       rx_active;
  int         rx_cnt;
  logic [9:0] rx_bits;
  int         decoded = 0;
  logic       saw_ready2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_ptr = NUM_REQ - 1;
    m_data = 8'h00;
    m_gid = 0;
    work_en = 1'b0;
    tx_pos = 0;
    rx_active = 1'b0;
    rx_cnt = 0;
    rx_bits = '0;
    exp_q.delete();
  endtask

  function automatic int pick();
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // ---------------- one clock cycle: check, model, driver hook ----------------
  task automatic step();
    int w;
    int b;
    logic [NUM_REQ-1:0] exp_ready;
    logic line;
    @(negedge sclk);
    cyc++;
    hs_w = -1;
    if (!s_rst_n) begin
      model_reset();
      w = -1;
    end else begin
      w = (m_left == 0) ? pick() : -1;
    end
    exp_ready = (w >= 0) ? (NUM_REQ'(1) << w) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("tx_flag", 32'(tx_flag), 32'(s_rst_n && m_left == FC));
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    chk("grant_id", 32'(grant_id), 32'(m_gid));

    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) got_q.push_back(i);
    if (req_ready[2]) saw_ready2 = 1'b1;
    if (tx_flag) flag_cyc.push_back(cyc);

    if (s_rst_n) begin
      line = 1'b1;
      if (work_en) begin
        b = tx_pos / BAUD;
        line = (b == 0) ? 1'b0 : (b == BITS - 1) ? 1'b1 : tx_data[b-1];
      end
      if (!rx_active && !line) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
      if (rx_active) begin
        if (rx_cnt % BAUD == BAUD / 2) begin
          rx_bits[rx_cnt / BAUD] = line;
          if (rx_cnt / BAUD == BITS - 1) begin
            chk("rx_start_bit", 32'(rx_bits[0]), 32'd0);
            chk("rx_stop_bit", 32'(rx_bits[9]), 32'd1);
            chk("rx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("rx_byte", 32'(rx_bits[8:1]), 32'(exp_q.pop_front()));
            decoded++;
            rx_active = 1'b0;
          end
        end
        rx_cnt++;
      end
      if (tx_flag) chk("flag_while_work_en", 32'(work_en), 32'd0);
      if (work_en) begin
        tx_pos++;
        if (tx_pos == FC) work_en = 1'b0;
      end
      if (tx_flag) begin
        work_en = 1'b1;
        tx_pos = 0;
      end
    end

    if (w >= 0) begin
      m_data = req_data[8*w +: 8];
      m_gid = w;
      m_ptr = w;
      m_left = FC;
      exp_q.push_back(m_data);
      hs_w = w;
    end else if (m_left > 0) begin
      m_left--;
    end
    @(posedge sclk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      if (hs_w >= 0 && auto_clear) req_valid[hs_w] = 1'b0;
    end
  endtask

  task automatic run_until_flag(input int limit);
    int f;
    int n;
    f = flag_cyc.size();
    n = 0;
    while (flag_cyc.size() == f && n < limit) begin
      run(1);
      n++;
    end
    chk("flag_wait_timeout", 32'(flag_cyc.size() > f), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n0;
    int f0;
    int d0;
    int n;
    model_reset();
    #1 s_rst_n = 1'b0;
    run(3);
    s_rst_n = 1'b1;

    // Single request on req1.
    n0 = got_q.size();
    f0 = flag_cyc.size();
    req_data[15:8] = 8'hA5;
    req_valid = 4'b0010;
    run(FC + 10);
    chk("single_grant_count", 32'(got_q.size() - n0), 32'd1);
    if (got_q.size() > n0) chk("single_grant_id", 32'(got_q[n0]), 32'd1);
    chk("single_flag_count", 32'(flag_cyc.size() - f0), 32'd1);
    chk("single_busy_end", 32'(busy), 32'd0);

    // Contention after a fresh reset: order 0,1,2,3 then only req0/req2.
    s_rst_n = 1'b0;
    run(2);
    s_rst_n = 1'b1;
    got_q.delete();
    flag_cyc.delete();
    auto_clear = 1'b0;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    n = 0;
    while (got_q.size() < 4 && n < 5 * (FC + 1)) begin
      run(1);
      n++;
    end
    chk("contention_timeout", 32'(got_q.size() >= 4), 32'd1);
    req_valid = 4'b0101;
    auto_clear = 1'b1;
    run(3 * FC);
    chk("order_len", 32'(got_q.size()), 32'd6);
    if (got_q.size() == 6) begin
      chk("order_0", 32'(got_q[0]), 32'd0);
      chk("order_1", 32'(got_q[1]), 32'd1);
      chk("order_2", 32'(got_q[2]), 32'd2);
      chk("order_3", 32'(got_q[3]), 32'd3);
      chk("wrap_req0", 32'(got_q[4]), 32'd0);
      chk("wrap_req2", 32'(got_q[5]), 32'd2);
    end
    if (flag_cyc.size() >= 6) begin
      for (int i = 1; i < 6; i++) chk("flag_spacing", 32'(flag_cyc[i] - flag_cyc[i-1]), 32'(FC + 1));
    end

    // Back-to-back bytes through the line model.
    d0 = decoded;
    req_data[15:8] = 8'h3C;
    req_data[23:16] = 8'hC3;
    req_valid = 4'b0110;
    run(2 * FC + 40);
    chk("cosim_decoded", 32'(decoded - d0), 32'd2);

    // Reset in the middle of a frame.
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    run_until_flag(FC + 10);
    run(40);
    s_rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_flag", 32'(tx_flag), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    chk("midrst_grant_id", 32'(grant_id), 32'd0);
    req_data[15:8] = 8'h5B;
    req_valid = 4'b0010;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    run(2);
    s_rst_n = 1'b1;
    n0 = got_q.size();
    run(FC + 10);
    if (got_q.size() > n0) chk("post_rst_grant", 32'(got_q[n0]), 32'd1);
    chk("post_rst_grant_count", 32'(got_q.size() - n0), 32'd1);

    // Withdrawn request: req2 drops before IDLE, req3 stays.
    req_data[15:8] = 8'h66;
    req_valid = 4'b0010;
    run_until_flag(FC + 10);
    run(5);
    req_data[31:16] = {8'h77, 8'h22};
    req_valid[3] = 1'b1;
    req_valid[2] = 1'b1;
    saw_ready2 = 1'b0;
    run(3);
    req_valid[2] = 1'b0;
    n0 = got_q.size();
    run(FC + 10);
    chk("withdraw_no_ready2", 32'(saw_ready2), 32'd0);
    if (got_q.size() > n0) chk("withdraw_req3", 32'(got_q[n0]), 32'd3);

    // Random traffic with occasional withdrawals.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_valid[i] = 1'b1;
            req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      run(1);
    end
    req_valid = '0;
    run(2 * FC + 10);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
